// File: rtl/rate_ctrl_pkg.sv
// Shared types and default parameters for the rate_controller tick generator.
package rate_ctrl_pkg;

  localparam int CNT_W_DEF       = 23;
  localparam int DEFAULT_DIV_DEF = 2500000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

endpackage

// File: rtl/rate_controller_tick_counter.sv
// Divider counter: counts enabled cycles and flags the wrap when the count reaches div-1.
module tick_counter #(
  parameter int CNT_W = rate_ctrl_pkg::CNT_W_DEF
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;

  assign wrap = enable && (cnt_r == (div - ONE));

  // Count register; clear wins over enable so an exit to IDLE always restarts from 0.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (clear) begin
      cnt_r <= ZERO;
    end else if (enable) begin
      cnt_r <= wrap ? ZERO : (cnt_r + ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rate_controller.sv
// Programmable tick generator with run/step control and deferred divide-value loads.
// Optional square-wave output clock_out is enabled by defining RATE_CTRL_CLKOUT_EN.
module rate_controller
  import rate_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             load_valid,
  input  logic [CNT_W-1:0] load_value,
  output logic             load_ready,
  output logic             tick,
  output logic             running,
  output logic [15:0]      tick_count
`ifdef RATE_CTRL_CLKOUT_EN
  ,
  output logic             clock_out
`endif
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] div_next_s;
  logic             pend_r;
  logic             pend_next_s;
  logic [CNT_W-1:0] pend_val_r;
  logic [CNT_W-1:0] pend_val_next_s;
  logic             tick_r;
  logic             running_r;
  logic             load_ready_r;
  logic [15:0]      tick_count_r;
  logic             enable_s;
  logic             clear_s;
  logic             wrap_s;
  logic             tick_next_s;
  logic             accept_s;
  logic [CNT_W-1:0] load_clamped_s;

  // Next-state logic; a step leaves STEP in the cycle its tick is visible.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (stop) begin
          state_next_s = IDLE;
        end else if (start) begin
          state_next_s = RUN;
        end else if (step) begin
          state_next_s = STEP;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      STEP: begin
        if (stop || tick_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STEP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  assign enable_s       = (state_r == RUN) || ((state_r == STEP) && !tick_r);
  assign clear_s        = (state_next_s == IDLE);
  assign tick_next_s    = wrap_s && (state_next_s != IDLE);
  assign accept_s       = load_valid && load_ready_r;
  assign load_clamped_s = (load_value == ZERO) ? ONE : load_value;

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable_s),
    .clear    (clear_s),
    .div      (div_r),
    .wrap     (wrap_s)
  );

  // Load path: direct write when idle or leaving, otherwise park until the wrap.
  always_comb begin
    div_next_s      = div_r;
    pend_next_s     = pend_r;
    pend_val_next_s = pend_val_r;
    if (accept_s) begin
      if ((state_r == IDLE) || (state_next_s == IDLE)) begin
        div_next_s = load_clamped_s;
      end else begin
        pend_next_s     = 1'b1;
        pend_val_next_s = load_clamped_s;
      end
    end else if (pend_r && (wrap_s || (state_next_s == IDLE))) begin
      div_next_s  = pend_val_r;
      pend_next_s = 1'b0;
    end else begin
      div_next_s = div_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_r      <= IDLE;
      div_r        <= DIV_INIT;
      pend_r       <= 1'b0;
      pend_val_r   <= ZERO;
      tick_r       <= 1'b0;
      running_r    <= 1'b0;
      load_ready_r <= 1'b1;
      tick_count_r <= 16'd0;
    end else begin
      state_r      <= state_next_s;
      div_r        <= div_next_s;
      pend_r       <= pend_next_s;
      pend_val_r   <= pend_val_next_s;
      tick_r       <= tick_next_s;
      running_r    <= (state_next_s != IDLE);
      load_ready_r <= !pend_next_s;
      tick_count_r <= tick_next_s ? (tick_count_r + 16'd1) : tick_count_r;
    end
  end

  assign tick       = tick_r;
  assign running    = running_r;
  assign load_ready = load_ready_r;
  assign tick_count = tick_count_r;

`ifdef RATE_CTRL_CLKOUT_EN
  logic clock_out_r;

  // Square wave: one toggle per tick, aligned with the tick pulse.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      clock_out_r <= 1'b0;
    end else if (tick_next_s) begin
      clock_out_r <= ~clock_out_r;
    end else begin
      clock_out_r <= clock_out_r;
    end
  end

  assign clock_out = clock_out_r;
`endif

endmodule
